// File: rtl/iir_biquad_seq_pkg.sv
// Shared types and default constants for the sequenced biquad IIR filter.
// The accumulator width follows from the sample and coefficient widths.
package iir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAC0,
        MAC1,
        MAC2,
        MAC3,
        OUT
    } state_t;

    localparam int W_DEF     = 8;
    localparam int CW_DEF    = 8;
    localparam int A0_DEF    = 3;
    localparam int A1_DEF    = 3;
    localparam int B1_DEF    = 4;
    localparam int B2_DEF    = 2;
    localparam int SHIFT_DEF = 3;

    function automatic int acc_width(input int w, input int cw);
        return w + cw + 3;
    endfunction

    localparam int ACC_W = acc_width(W_DEF, CW_DEF);

endpackage

// File: rtl/iir_biquad_seq_if.sv
// Sample-in / sample-out valid-ready bundle for the biquad filter.
// The slave side is the filter; the master side is the source plus sink.
interface iir_biquad_seq_if #(
    parameter int W = 8
);
    logic [W-1:0] x_in;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] y_out;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output x_in, in_valid, out_ready,
        input  in_ready, y_out, out_valid
    );

    modport slave (
        input  x_in, in_valid, out_ready,
        output in_ready, y_out, out_valid
    );
endinterface

// File: rtl/iir_biquad_seq_sat_unsigned.sv
// Clamps a signed accumulator value into the unsigned range 0..2^W-1.
// Shared with the FIR smoother.
module sat_unsigned #(
    parameter int W     = 8,
    parameter int ACC_W = 19
) (
    input  logic signed [ACC_W-1:0] v,
    output logic        [W-1:0]     y
);

    function automatic logic [W-1:0] sat_fn(input logic signed [ACC_W-1:0] a);
        if (a[ACC_W-1])
            return '0;
        else if (|a[ACC_W-2:W])
            return '1;
        else
            return a[W-1:0];
    endfunction

    assign y = sat_fn(v);

endmodule

// File: rtl/iir_biquad_seq.sv
// Second-order IIR low-pass filter using one shared MAC sequenced over four
// terms per sample, with valid/ready handshakes on both sides.
module iir_biquad_seq
    import iir_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CW    = CW_DEF,
    parameter int A0    = A0_DEF,
    parameter int A1    = A1_DEF,
    parameter int B1    = B1_DEF,
    parameter int B2    = B2_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    iir_biquad_seq_if.slave   bus,
    output logic              busy
);

    localparam int ACC_BITS = acc_width(W, CW);

    localparam logic signed [CW-1:0] C_A0 = CW'(A0);
    localparam logic signed [CW-1:0] C_A1 = CW'(A1);
    localparam logic signed [CW-1:0] C_B1 = CW'(B1);
    localparam logic signed [CW-1:0] C_B2 = CW'(B2);

    state_t                      state;
    logic                        tail;
    logic        [W-1:0]         xs, x1, y1, y2;
    logic        [W-1:0]         y_reg;
    logic                        out_valid_reg;
    logic signed [ACC_BITS-1:0]  acc;

    logic        [W-1:0]         opnd;
    logic signed [CW-1:0]        coef;
    logic                        sub;
    logic signed [ACC_BITS-1:0]  coef_x, opnd_x, term, acc_next, shifted;
    logic        [W-1:0]         y_sat;

    // Operand/coefficient select for the shared multiplier
    always_comb begin
        opnd = xs;
        coef = C_A0;
        sub  = 1'b0;
        case (state)
            MAC1: begin opnd = x1; coef = C_A1; end
            MAC2: begin opnd = y1; coef = C_B1; end
            MAC3: begin opnd = y2; coef = C_B2; sub = 1'b1; end
            default: ;
        endcase
    end

    // Samples are zero-extended, so the operand is always non-negative
    assign coef_x   = {{(ACC_BITS-CW){coef[CW-1]}}, coef};
    assign opnd_x   = {{(ACC_BITS-W){1'b0}}, opnd};
    assign term     = coef_x * opnd_x;
    assign acc_next = sub ? (acc - term) : (acc + term);
    assign shifted  = acc >>> SHIFT;

    sat_unsigned #(
        .W     (W),
        .ACC_W (ACC_BITS)
    ) u_sat (
        .v (shifted),
        .y (y_sat)
    );

    assign bus.in_ready  = (state == IDLE);
    assign bus.y_out     = y_reg;
    assign bus.out_valid = out_valid_reg;
    assign busy          = (state != IDLE);

    // MAC3 spends two cycles: last term, then saturate and publish
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            tail          <= 1'b0;
            xs            <= '0;
            x1            <= '0;
            y1            <= '0;
            y2            <= '0;
            y_reg         <= '0;
            out_valid_reg <= 1'b0;
            acc           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        xs    <= bus.x_in;
                        acc   <= '0;
                        tail  <= 1'b0;
                        state <= MAC0;
                    end
                end
                MAC0: begin acc <= acc_next; state <= MAC1; end
                MAC1: begin acc <= acc_next; state <= MAC2; end
                MAC2: begin acc <= acc_next; state <= MAC3; end
                MAC3: begin
                    if (!tail) begin
                        acc  <= acc_next;
                        tail <= 1'b1;
                    end else begin
                        y_reg         <= y_sat;
                        out_valid_reg <= 1'b1;
                        y2            <= y1;
                        y1            <= y_sat;
                        x1            <= xs;
                        tail          <= 1'b0;
                        state         <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_biquad_seq.sv
// Directed bench for iir_biquad_seq: reset, step, impulse/clamp, backpressure,
// mid-operation reset and back-to-back sources with hand-computed outputs.
module tb_iir_biquad_seq;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    int   total = 0;
    int   bad = 0;

    iir_biquad_seq_if #(.W(8)) bus ();

    iir_biquad_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offer one sample, wait for the output, check value; handshake if out_ready=1
    task automatic run_sample(input string tag, input logic [7:0] x, input logic [7:0] exp,
                              output int lat);
        int n;
        bus.x_in     = x;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 40) begin tick(); n++; end
        chk({tag, "_rdy"}, bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin tick(); lat++; end
        chk({tag, "_vld"}, bus.out_valid, 1);
        chk(tag, bus.y_out, exp);
        if (bus.out_ready) tick();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] step_y [10] = '{30, 75, 90, 86, 80, 78, 79, 80, 80, 80};
        logic [7:0] imp_x  [6]  = '{255, 0, 0, 0, 0, 0};
        logic [7:0] imp_y  [6]  = '{95, 143, 47, 0, 0, 0};
        logic [7:0] bb_x   [4]  = '{16, 40, 0, 8};
        logic [7:0] bb_y   [4]  = '{6, 24, 25, 9};
        int lat;
        int k, nout, last_acc, cyc;
        logic acc_now, out_now;

        bus.x_in = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_y_out", bus.y_out, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        tick();
        run_sample("zero_in", 8'd0, 8'd0, lat);

        // Step response; first sample also checks latency from accept edge
        for (int i = 0; i < 10; i++) begin
            run_sample($sformatf("step%0d", i), 8'd80, step_y[i], lat);
            if (i == 0) chk("latency", lat, 5);
        end

        // Impulse with negative clamp
        pulse_reset();
        for (int i = 0; i < 6; i++)
            run_sample($sformatf("imp%0d", i), imp_x[i], imp_y[i], lat);

        // Backpressure: hold the first step output for 7 cycles
        pulse_reset();
        bus.out_ready = 1'b0;
        run_sample("bp_first", 8'd80, 8'd30, lat);
        for (int i = 0; i < 7; i++) begin
            bus.x_in     = 8'd200;
            bus.in_valid = (i == 3);
            chk($sformatf("bp_vld%0d", i), bus.out_valid, 1);
            chk($sformatf("bp_y%0d", i), bus.y_out, 30);
            chk($sformatf("bp_rdy%0d", i), bus.in_ready, 0);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_vld", bus.out_valid, 0);
        chk("bp_release_rdy", bus.in_ready, 1);
        chk("bp_release_busy", busy, 0);
        run_sample("bp_next", 8'd80, 8'd75, lat);

        // Reset while the second step sample is in MAC2
        pulse_reset();
        run_sample("mr_first", 8'd80, 8'd30, lat);
        bus.x_in = 8'd80;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("mr_busy_pre", busy, 1);
        reset = 1'b1;
        #1;
        chk("mr_vld_async", bus.out_valid, 0);
        chk("mr_busy_async", busy, 0);
        tick();
        reset = 1'b0;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid) cyc++;
        end
        chk("mr_no_output", cyc, 0);
        run_sample("mr_after", 8'd80, 8'd30, lat);

        // Back-to-back source: in_valid held high, new value per accept
        pulse_reset();
        k = 0;
        nout = 0;
        last_acc = -100;
        bus.x_in = bb_x[0];
        bus.in_valid = 1'b1;
        for (cyc = 0; cyc < 120 && nout < 4; cyc++) begin
            acc_now = bus.in_valid && bus.in_ready;
            out_now = bus.out_valid && bus.out_ready;
            if (out_now) begin
                chk($sformatf("bb_y%0d", nout), bus.y_out, bb_y[nout]);
                nout++;
            end
            tick();
            if (acc_now) begin
                if (k > 0) chk($sformatf("bb_gap%0d", k), (cyc - last_acc) >= 6, 1);
                last_acc = cyc;
                k++;
                if (k < 4) bus.x_in = bb_x[k];
                else bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        chk("bb_accepts", k, 4);
        chk("bb_outputs", nout, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
